// File: rtl/wb_sevseg_scanner.sv
// Wishbone 7-segment scanner for N common-anode digits with hex decode,
// 8-bit PWM brightness, per-digit blink and decimal points.
module wb_sevseg_scanner #(
  parameter int N_DIGITS     = 8,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [4:0]          i_wb_adr,
  input  logic [31:0]         i_wb_dat,
  input  logic [3:0]          i_wb_sel,
  input  logic                i_wb_we,
  input  logic                i_wb_cyc,
  input  logic                i_wb_stb,
  output logic [31:0]         o_wb_rdt,
  output logic                o_wb_ack,
  output logic [N_DIGITS-1:0] o_an,
  output logic [6:0]          o_seg,
  output logic                o_dp,
  output logic                o_frame
);

  localparam int N_WORDS = N_DIGITS / 4;
  localparam int IW = $clog2(N_DIGITS);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_FRAMES + 1);

  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [N_DIGITS-1:0] AN_ONE = N_DIGITS'(1);

  logic [7:0]          digit [N_DIGITS];
  logic                decode;
  logic                blink_en;
  logic [7:0]          bright;
  logic [N_DIGITS-1:0] dp_mask;
  logic [N_DIGITS-1:0] blink_mask;

  logic [PW-1:0] presc;
  logic [IW-1:0] idx;
  logic [7:0]    pwm_cnt;
  logic [7:0]    frame_cnt;
  logic [BW-1:0] blk_cnt;
  logic          blink_phase;

  logic        acc;
  logic        wr;
  logic [2:0]  wsel;
  logic [31:0] digit_word;
  logic [31:0] dp_word;
  logic [31:0] blink_word;
  logic [31:0] stat_word;
  logic [31:0] rd_data;
  logic [31:0] dp_merged;
  logic [31:0] blink_merged;

  function automatic logic [31:0] bmerge(
    input logic [31:0] old,
    input logic [31:0] dat,
    input logic [3:0]  sel
  );
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      r[8*b +: 8] = sel[b] ? dat[8*b +: 8] : old[8*b +: 8];
    return r;
  endfunction

  // Ack only on the first cycle of a strobe so each access writes once.
  assign acc  = i_wb_cyc & i_wb_stb & ~o_wb_ack;
  assign wr   = acc & i_wb_we;
  assign wsel = i_wb_adr[4:2];

  assign dp_word    = 32'(dp_mask);
  assign blink_word = 32'(blink_mask);
  assign stat_word  = {16'h0, frame_cnt, 3'b0, blink_phase, 4'(idx)};

  assign dp_merged    = bmerge(dp_word, i_wb_dat, i_wb_sel);
  assign blink_merged = bmerge(blink_word, i_wb_dat, i_wb_sel);

  always_comb begin
    digit_word = '0;
    for (int w = 0; w < N_WORDS; w++)
      if (wsel == 3'(w))
        digit_word = {digit[4*w+3], digit[4*w+2],
                      digit[4*w+1], digit[4*w]};
  end

  always_comb begin
    rd_data = '0;
    unique case (wsel)
      3'd4:    rd_data = {16'h0, bright, 6'h0, blink_en, decode};
      3'd5:    rd_data = dp_word;
      3'd6:    rd_data = blink_word;
      3'd7:    rd_data = stat_word;
      default: rd_data = digit_word;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_wb_ack <= 1'b0;
      o_wb_rdt <= '0;
    end else begin
      o_wb_ack <= i_wb_cyc & i_wb_stb & ~o_wb_ack;
      if (acc)
        o_wb_rdt <= rd_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < N_DIGITS; i++)
        digit[i] <= '0;
      decode     <= 1'b0;
      blink_en   <= 1'b0;
      bright     <= 8'hFF;
      dp_mask    <= '0;
      blink_mask <= '0;
    end else if (wr) begin
      for (int i = 0; i < N_DIGITS; i++)
        if (wsel == 3'(i / 4) && i_wb_sel[i % 4])
          digit[i] <= i_wb_dat[8*(i%4) +: 8];
      if (wsel == 3'd4) begin
        if (i_wb_sel[0])
          {blink_en, decode} <= i_wb_dat[1:0];
        if (i_wb_sel[1])
          bright <= i_wb_dat[15:8];
      end
      if (wsel == 3'd5)
        dp_mask <= dp_merged[N_DIGITS-1:0];
      if (wsel == 3'd6)
        blink_mask <= blink_merged[N_DIGITS-1:0];
    end
  end

  logic slot_end;
  logic frame_wrap;

  assign slot_end   = presc == PRE_LAST;
  assign frame_wrap = slot_end & (idx == IDX_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      presc       <= '0;
      idx         <= '0;
      pwm_cnt     <= '0;
      frame_cnt   <= '0;
      blk_cnt     <= '0;
      blink_phase <= 1'b0;
      o_frame     <= 1'b0;
    end else begin
      presc   <= slot_end ? '0 : presc + PW'(1);
      pwm_cnt <= slot_end ? '0 : pwm_cnt + 8'd1;
      o_frame <= frame_wrap;
      if (slot_end)
        idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      if (frame_wrap) begin
        frame_cnt <= frame_cnt + 8'd1;
        if (blk_cnt == BLK_LAST) begin
          blk_cnt     <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blk_cnt <= blk_cnt + BW'(1);
        end
      end
    end
  end

  logic [7:0] cur;
  logic [6:0] hex_seg;
  logic [6:0] pattern;
  logic       pwm_on;
  logic       lit;

  assign cur = digit[idx];

  always_comb begin
    hex_seg = 7'h00;
    unique case (cur[3:0])
      4'h0: hex_seg = 7'h3F;
      4'h1: hex_seg = 7'h06;
      4'h2: hex_seg = 7'h5B;
      4'h3: hex_seg = 7'h4F;
      4'h4: hex_seg = 7'h66;
      4'h5: hex_seg = 7'h6D;
      4'h6: hex_seg = 7'h7D;
      4'h7: hex_seg = 7'h07;
      4'h8: hex_seg = 7'h7F;
      4'h9: hex_seg = 7'h6F;
      4'hA: hex_seg = 7'h77;
      4'hB: hex_seg = 7'h7C;
      4'hC: hex_seg = 7'h39;
      4'hD: hex_seg = 7'h5E;
      4'hE: hex_seg = 7'h79;
      4'hF: hex_seg = 7'h71;
    endcase
  end

  assign pattern = decode ? hex_seg : cur[6:0];
  assign pwm_on  = (bright == 8'hFF) | (pwm_cnt < bright);
  assign lit     = cur[7] & pwm_on
                 & ~(blink_en & blink_mask[idx] & blink_phase);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_an  <= '1;
      o_seg <= 7'h7F;
      o_dp  <= 1'b1;
    end else begin
      o_an  <= lit ? ~(AN_ONE << idx) : '1;
      o_seg <= lit ? ~pattern : 7'h7F;
      o_dp  <= ~(dp_mask[idx] & lit);
    end
  end

  logic unused;
  assign unused = ^{i_wb_adr[1:0], dp_merged, blink_merged};

endmodule

// File: tb/tb_wb_sevseg_scanner.sv
// Scoreboard bench: stimulus queues expected reads and lit-digit runs,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_wb_sevseg_scanner;

  localparam int N = 8;
  localparam logic [6:0] HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [4:0]  i_wb_adr = '0;
  logic [31:0] i_wb_dat = '0;
  logic [3:0]  i_wb_sel = '0;
  logic        i_wb_we = 1'b0;
  logic        i_wb_cyc = 1'b0;
  logic        i_wb_stb = 1'b0;
  logic [31:0] o_wb_rdt;
  logic        o_wb_ack;
  logic [N-1:0] o_an;
  logic [6:0]  o_seg;
  logic        o_dp;
  logic        o_frame;

  wb_sevseg_scanner #(
    .N_DIGITS(N), .SCAN_DIV(4), .BLINK_FRAMES(2)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_wb_adr(i_wb_adr), .i_wb_dat(i_wb_dat),
    .i_wb_sel(i_wb_sel), .i_wb_we(i_wb_we),
    .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb),
    .o_wb_rdt(o_wb_rdt), .o_wb_ack(o_wb_ack),
    .o_an(o_an), .o_seg(o_seg), .o_dp(o_dp),
    .o_frame(o_frame)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    int         len;
    int         gap;
  } run_t;

  run_t        disp_q[$];
  logic [31:0] rd_q[$];
  int          checks = 0;
  int          failures = 0;
  logic        mon_en = 1'b0;
  int          lit_cycles = 0;

  initial begin : monitor
    logic [7:0]  prev_an;
    logic [6:0]  run_seg;
    logic        run_dp;
    logic [31:0] erd;
    int          run_len;
    int          last_gap;
    bit          active;
    bit          partial;
    run_t        e;
    active = 0;
    prev_an = '1;
    run_seg = '0;
    run_dp = 1'b1;
    run_len = 0;
    last_gap = -1;
    partial = 1;
    forever begin
      @(negedge i_clk);
      if (i_wb_cyc && i_wb_stb && o_wb_ack && !i_wb_we) begin
        checks++;
        if (rd_q.size() == 0) begin
          failures++;
          $display("FAIL rd_unexpected adr=%h got=%h", i_wb_adr, o_wb_rdt);
        end else begin
          erd = rd_q.pop_front();
          if (o_wb_rdt !== erd) begin
            failures++;
            $display("FAIL rd adr=%h got=%h want=%h", i_wb_adr, o_wb_rdt, erd);
          end
        end
      end
      if (!mon_en) begin
        active = 0;
      end else if (!active) begin
        active = 1;
        partial = 1;
        prev_an = o_an;
        run_seg = o_seg;
        run_dp = o_dp;
        run_len = 1;
        last_gap = -1;
      end else if (o_an == prev_an) begin
        run_len++;
      end else begin
        if (prev_an != 8'hFF) begin
          if (!partial) begin
            checks++;
            if (disp_q.size() == 0) begin
              failures++;
              $display("FAIL disp_unexpected an=%h len=%0d", prev_an, run_len);
            end else begin
              e = disp_q.pop_front();
              if (e.an !== prev_an || e.seg !== run_seg || e.dp !== run_dp ||
                  e.len != run_len || (e.gap >= 0 && e.gap != last_gap)) begin
                failures++;
                $display("FAIL disp got an=%h seg=%h dp=%b len=%0d gap=%0d want an=%h seg=%h dp=%b len=%0d gap=%0d",
                         prev_an, run_seg, run_dp, run_len, last_gap,
                         e.an, e.seg, e.dp, e.len, e.gap);
              end
            end
          end
          last_gap = 0;
        end else begin
          last_gap = partial ? -1 : run_len;
        end
        partial = 0;
        prev_an = o_an;
        run_seg = o_seg;
        run_dp = o_dp;
        run_len = 1;
      end
      if (mon_en && o_an != 8'hFF)
        lit_cycles++;
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic bus(input logic [4:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel, input logic we);
    i_wb_adr = adr;
    i_wb_dat = dat;
    i_wb_sel = sel;
    i_wb_we  = we;
    i_wb_cyc = 1'b1;
    i_wb_stb = 1'b1;
    @(posedge i_clk);
    #1;
    chk("ack_latency", 32'(o_wb_ack), 32'd1);
    @(posedge i_clk);
    #1;
    i_wb_cyc = 1'b0;
    i_wb_stb = 1'b0;
    i_wb_we  = 1'b0;
  endtask

  task automatic wr(input logic [4:0] adr, input logic [31:0] dat,
                    input logic [3:0] sel);
    bus(adr, dat, sel, 1'b1);
  endtask

  task automatic rd(input logic [4:0] adr, input logic [31:0] exp);
    rd_q.push_back(exp);
    bus(adr, 32'h0, 4'hF, 1'b0);
  endtask

  task automatic push_run(input logic [7:0] an, input logic [6:0] seg,
                          input logic dp, input int len, input int gap);
    run_t r;
    r.an = an;
    r.seg = seg;
    r.dp = dp;
    r.len = len;
    r.gap = gap;
    disp_q.push_back(r);
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
  endtask

  task automatic reset_outputs();
    chk("rst_an", 32'(o_an), 32'hFF);
    chk("rst_seg", 32'(o_seg), 32'h7F);
    chk("rst_dp", 32'(o_dp), 32'h1);
    chk("rst_frame", 32'(o_frame), 32'h0);
    chk("rst_ack", 32'(o_wb_ack), 32'h0);
    chk("rst_rdt", o_wb_rdt, 32'h0);
  endtask

  task automatic align_frame();
    bit ok;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge i_clk);
      #1;
      if (o_frame) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL frame_timeout o_frame=0 want pulse");
    end
  endtask

  initial begin : stim
    logic [6:0] raw [8];
    int cyc;
    do_reset();
    reset_outputs();
    rd(5'h10, 32'h0000FF00);
    rd(5'h14, 32'h0);
    rd(5'h18, 32'h0);
    rd(5'h08, 32'h0);

    wr(5'h00, 32'h86858483, 4'hF);
    wr(5'h04, 32'h8A898887, 4'hF);
    for (int f = 0; f < 2; f++)
      for (int k = 0; k < N; k++)
        push_run(~(8'd1 << k), ~7'(3 + k), 1'b1, 4, 0);
    align_frame();
    mon_en = 1'b1;
    repeat (66) @(posedge i_clk);
    #1;
    mon_en = 1'b0;
    chk("scan_drain", 32'(disp_q.size()), 32'd0);

    align_frame();
    cyc = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge i_clk);
      #1;
      if (o_frame) begin
        cyc = i;
        break;
      end
    end
    chk("frame_period", 32'(cyc), 32'd32);

    wr(5'h14, 32'h1, 4'hF);
    wr(5'h10, 32'h0000FF01, 4'hF);
    wr(5'h00, 32'h0000008A, 4'b0001);
    for (int k = 0; k < N; k++)
      push_run(~(8'd1 << k), ~HEX[k == 0 ? 10 : 3 + k],
               k == 0 ? 1'b0 : 1'b1, 4, 0);
    align_frame();
    mon_en = 1'b1;
    repeat (34) @(posedge i_clk);
    #1;
    mon_en = 1'b0;
    chk("decode_drain", 32'(disp_q.size()), 32'd0);

    wr(5'h00, 32'hFFFFFFFF, 4'b0010);
    rd(5'h00, 32'h8685FF8A);
    wr(5'h08, 32'h12345678, 4'hF);
    rd(5'h08, 32'h0);
    rd(5'h14, 32'h1);

    wr(5'h10, 32'h00000200, 4'hF);
    raw = '{7'h0A, 7'h7F, 7'h05, 7'h06, 7'h07, 7'h08, 7'h09, 7'h0A};
    for (int k = 0; k < N; k++)
      push_run(~(8'd1 << k), ~raw[k], k == 0 ? 1'b0 : 1'b1, 2,
               k == 0 ? -1 : 2);
    align_frame();
    mon_en = 1'b1;
    repeat (32) @(posedge i_clk);
    #1;
    mon_en = 1'b0;
    chk("pwm_drain", 32'(disp_q.size()), 32'd0);

    wr(5'h10, 32'h00000000, 4'hF);
    align_frame();
    lit_cycles = 0;
    mon_en = 1'b1;
    repeat (64) @(posedge i_clk);
    #1;
    mon_en = 1'b0;
    chk("dark_lit_cycles", 32'(lit_cycles), 32'd0);

    wr(5'h10, 32'h0000FF00, 4'hF);
    repeat (5) @(posedge i_clk);
    #1;
    do_reset();
    reset_outputs();
    mon_en = 1'b1;
    push_run(8'hFE, ~7'h03, 1'b1, 4, -1);
    push_run(8'hFE, ~7'h03, 1'b1, 4, 92);
    push_run(8'hFE, ~7'h03, 1'b1, 4, 28);
    push_run(8'hFE, ~7'h03, 1'b1, 4, 92);
    push_run(8'hFE, ~7'h03, 1'b1, 4, 28);
    @(posedge i_clk);
    #1;
    wr(5'h18, 32'h1, 4'hF);
    wr(5'h10, 32'h0000FF02, 4'hF);
    wr(5'h00, 32'h00000083, 4'hF);
    repeat (63) @(posedge i_clk);
    #1;
    rd(5'h1C, 32'h00000211);
    repeat (68) @(posedge i_clk);
    #1;
    rd(5'h1C, 32'h00000403);
    repeat (158) @(posedge i_clk);
    #1;
    mon_en = 1'b0;
    chk("blink_drain", 32'(disp_q.size()), 32'd0);
    rd(5'h14, 32'h0);
    rd(5'h00, 32'h00000083);
    rd(5'h10, 32'h0000FF02);
    repeat (2) @(posedge i_clk);
    chk("rd_drain", 32'(rd_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
